// File: rtl/mem_if_pkg.sv
// Shared definitions for the 128-bit block-transfer busywait memory interface.
// Used by the main_memory responder and by the cache modules' memory-side ports.
package mem_if_pkg;

  localparam int BLOCK_BITS      = 128;
  localparam int BLOCK_ADDR_BITS = 28;
  localparam int DEFAULT_LATENCY = 5;

  typedef logic [BLOCK_BITS-1:0]      block_t;
  typedef logic [BLOCK_ADDR_BITS-1:0] block_addr_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;

endpackage

// File: rtl/main_memory_if.sv
// Block-transfer busywait bus between a cache (master) and a memory (slave).
interface main_memory_if;
  import mem_if_pkg::*;

  logic        read;
  logic        write;
  block_addr_t address;
  block_t      writedata;
  block_t      readdata;
  logic        busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );

endinterface

// File: rtl/mem_latency_counter.sv
// 8-bit loadable down-counter that paces the ACCESS phase of a memory transaction.
// Stops at zero; zero flag is combinational from the count.
module mem_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       en,
  output logic       zero
);

  logic [7:0] count;

  assign zero = (count == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && !zero) begin
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/main_memory.sv
// Behavioural block memory answering one 128-bit read or write at a time after
// LATENCY cycles of ACCESS, followed by a single RESPOND cycle.
module main_memory
  import mem_if_pkg::*;
#(
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter int ADDR_BITS = 8
) (
  input logic          CLK,
  input logic          RESET,
  main_memory_if.slave bus
);

  localparam int         DEPTH      = 1 << ADDR_BITS;
  localparam logic [7:0] LOAD_VALUE = 8'(LATENCY - 1);

  logic [1:0]           state;
  logic                 req_write;
  logic [ADDR_BITS-1:0] req_addr;
  block_t               req_data;
  block_t               readdata_q;
  block_t               mem [DEPTH];

  logic valid_req;
  logic start;
  logic in_access;
  logic cnt_zero;
  logic commit;

  // Upper address bits are ignored on purpose: blocks alias modulo DEPTH.
  if (ADDR_BITS < BLOCK_ADDR_BITS) begin : g_addr_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.address[BLOCK_ADDR_BITS-1:ADDR_BITS];
  end

  assign valid_req = bus.read ^ bus.write;
  assign start     = (state == ST_IDLE) && valid_req;
  assign in_access = (state == ST_ACCESS);
  assign commit    = in_access && cnt_zero;

  mem_latency_counter u_latency (
    .clk        (CLK),
    .rst        (RESET),
    .load       (start),
    .load_value (LOAD_VALUE),
    .en         (in_access),
    .zero       (cnt_zero)
  );

  // NOTE: the default assignment before the case keeps this purely combinational (no latch).
  always_comb begin
    bus.busywait = 1'b0;
    case (state)
      ST_IDLE:   bus.busywait = valid_req;
      ST_ACCESS: bus.busywait = 1'b1;
      default:   bus.busywait = 1'b0;
    endcase
  end

  assign bus.readdata = readdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      readdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_req) begin
            state     <= ST_ACCESS;
            req_write <= bus.write;
            req_addr  <= bus.address[ADDR_BITS-1:0];
            req_data  <= bus.writedata;
          end
        end
        ST_ACCESS: begin
          if (cnt_zero) begin
            state <= ST_RESPOND;
            if (!req_write) readdata_q <= mem[req_addr];
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; RESET only gates the commit so a reset edge drops a pending write.
  always_ff @(posedge CLK) begin
    if (!RESET && commit && req_write) mem[req_addr] <= req_data;
  end

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: a LATENCY=5 and a LATENCY=1 instance, with a
// scoreboard queue of expected READDATA values popped in each RESPOND cycle.
module tb_main_memory;
  import mem_if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  block_t model_mem [bit [8:0]];
  block_t model_rd  [2];
  block_t sb [$];

  main_memory_if bus5 ();
  main_memory_if bus1 ();

  main_memory #(.LATENCY(5), .ADDR_BITS(8)) dut5 (.CLK(clk), .RESET(rst), .bus(bus5));
  main_memory #(.LATENCY(1), .ADDR_BITS(8)) dut1 (.CLK(clk), .RESET(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [27:0] addr, input block_t wdata);
    if (sel) begin
      bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.writedata = wdata;
    end else begin
      bus5.read = rd; bus5.write = wr; bus5.address = addr; bus5.writedata = wdata;
    end
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? bus1.busywait : bus5.busywait;
  endfunction

  function automatic block_t get_rdata(input bit sel);
    return sel ? bus1.readdata : bus5.readdata;
  endfunction

  task automatic preload(input bit sel, input logic [7:0] idx, input block_t val);
    if (sel) dut1.mem[idx] <= val;
    else     dut5.mem[idx] <= val;
    model_mem[{sel, idx}] = val;
  endtask

  // Queue the expected READDATA for the RESPOND cycle of the access being issued.
  task automatic push_expect(input bit sel, input bit is_wr, input logic [27:0] addr, input block_t wdata);
    if (is_wr) begin
      sb.push_back(model_rd[sel]);
      model_mem[{sel, addr[7:0]}] = wdata;
    end else begin
      model_rd[sel] = model_mem[{sel, addr[7:0]}];
      sb.push_back(model_rd[sel]);
    end
  endtask

  // Full transaction from posedge+1 of the request cycle; returns at posedge+1 of the idle cycle after RESPOND.
  task automatic txn(input bit sel, input bit is_wr, input logic [27:0] addr,
                     input block_t wdata, input string tag);
    int n = 0;
    bit done = 0;
    block_t exp;
    push_expect(sel, is_wr, addr, wdata);
    drive(sel, !is_wr, is_wr, addr, wdata);
    for (int c = 0; c < 300 && !done; c++) begin
      #3;
      if (get_busy(sel)) n++;
      else done = 1;
      if (!done) next_cycle();
    end
    check({tag, "_busy_cycles"}, 128'(n), 128'((sel ? 1 : 5) + 1));
    exp = sb.pop_front();
    check({tag, "_readdata"}, get_rdata(sel), exp);
    next_cycle();
    drive(sel, 1'b0, 1'b0, '0, '0);
  endtask

  localparam block_t BLK_10 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
  localparam block_t BLK_DB = {4{32'hDEAD_BEEF}};
  localparam block_t BLK_AL = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam block_t BLK_20 = 128'h2020_2020_1111_2222_3333_4444_5555_6666;
  localparam block_t BLK_40 = 128'hAAAA_0000_BBBB_1111_CCCC_2222_DDDD_3333;
  localparam block_t BLK_41 = 128'h5555_6666_7777_8888_9999_0000_1234_5678;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    model_rd[0] = '0;
    model_rd[1] = '0;

    // Reset state
    next_cycle();
    next_cycle();
    #3;
    check("rst_rdata5", bus5.readdata, '0);
    check("rst_busy5",  128'(bus5.busywait), 128'(0));
    check("rst_rdata1", bus1.readdata, '0);
    check("rst_busy1",  128'(bus1.busywait), 128'(0));
    next_cycle();
    rst = 1'b0;
    preload(0, 8'h10, BLK_10);
    preload(0, 8'h20, BLK_20);
    preload(1, 8'h40, BLK_40);
    preload(1, 8'h41, BLK_41);
    next_cycle();

    // Read after preload, then write/read, then aliasing
    txn(0, 1'b0, 28'h10,       '0,     "read_preload");
    txn(0, 1'b1, 28'h03,       BLK_DB, "write_03");
    txn(0, 1'b0, 28'h03,       '0,     "read_03");
    txn(0, 1'b1, 28'h0000105,  BLK_AL, "write_alias");
    txn(0, 1'b0, 28'h0000005,  '0,     "read_alias");

    // Illegal request: both strobes high
    drive(0, 1'b1, 1'b1, 28'h10, BLK_DB);
    for (int i = 0; i < 3; i++) begin
      #3;
      check("illegal_busy",  128'(bus5.busywait), 128'(0));
      check("illegal_state", 128'(dut5.state), 128'(ST_IDLE));
      next_cycle();
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    txn(0, 1'b0, 28'h10, '0, "illegal_array");

    // Reset on the commit edge of a write
    drive(0, 1'b0, 1'b1, 28'h20, BLK_DB);
    for (int i = 0; i < 5; i++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    model_rd[0] = '0;
    model_rd[1] = '0;
    #3;
    check("midrst_busy",  128'(bus5.busywait), 128'(0));
    check("midrst_rdata", bus5.readdata, '0);
    check("midrst_state", 128'(dut5.state), 128'(ST_IDLE));
    next_cycle();
    txn(0, 1'b0, 28'h20, '0, "midrst_read");

    // Back-to-back reads on the LATENCY=1 instance with READ held high
    push_expect(1, 1'b0, 28'h40, '0);
    push_expect(1, 1'b0, 28'h41, '0);
    drive(1, 1'b1, 1'b0, 28'h40, '0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) drive(1, 1'b1, 1'b0, 28'h41, '0);
      #3;
      check($sformatf("b2b_busy_c%0d", i), 128'(bus1.busywait), 128'((i % 3) != 2));
      if (i == 2 || i == 5) check($sformatf("b2b_rdata_c%0d", i), bus1.readdata, sb.pop_front());
      next_cycle();
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    next_cycle();
    #3;
    check("b2b_idle_busy", 128'(bus1.busywait), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
